// File: rtl/led_bank_arbiter_if.sv
// LED bank sharing bus: requester side (req/pattern) and arbiter side (gnt/busy/led).
`timescale 1ns/1ps
interface led_bank_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] pattern;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [7:0]        led;

    modport master (output req, pattern, input gnt, busy, led);
    modport slave  (input req, pattern, output gnt, busy, led);
endinterface

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter granting the 8-LED bank to one of NREQ pattern requesters
// for up to HOLD_TICKS prescaled ticks. Optional idle heartbeat: LED_HEARTBEAT_EN.
`timescale 1ns/1ps
module led_bank_arbiter #(
    parameter int NREQ       = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int HOLD_TICKS = 500
) (
    input  logic               clk,
    input  logic               reset,
    led_bank_arbiter_if.slave  bus
);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int IDXW = $clog2(NREQ);
    localparam int PSW  = $clog2(DIV);
    localparam int HCW  = $clog2(HOLD_TICKS) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]      state;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] owner;
    logic [HCW-1:0]  hold_cnt;
    logic [PSW-1:0]  prescaler;
    logic            tick;

    logic [IDXW-1:0] pick;
    logic            pick_valid;
    logic [NREQ-1:0] pick_onehot;
    logic [IDXW-1:0] next_ptr;
    logic            hold_exit;
    logic [7:0]      idle_led;
    logic [7:0]      pat_arr [NREQ];
    int              j;

    // Free-running tick source; grant events never disturb its phase.
    assign tick = (prescaler == PSW'(DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pick        = '0;
        pick_valid  = 1'b0;
        pick_onehot = '0;
        j           = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!pick_valid && bus.req[j]) begin
                pick       = IDXW'(j);
                pick_valid = 1'b1;
            end
        end
        pick_onehot[pick] = 1'b1;
    end

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            pat_arr[k] = bus.pattern[8*k +: 8];
        end
    end

    assign next_ptr  = (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign hold_exit = !bus.req[owner] ||
                       (tick && (hold_cnt == HCW'(HOLD_TICKS - 1)));

`ifdef LED_HEARTBEAT_EN
    localparam int HB_TICKS = TICK_HZ / 2;
    localparam int HBW      = $clog2(HB_TICKS) + 1;

    logic           hb;
    logic [HBW-1:0] hb_cnt;

    // Heartbeat only advances while the bank is idle; it freezes across HOLD/GAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb     <= 1'b0;
            hb_cnt <= '0;
        end else if (state == IDLE && tick) begin
            if (hb_cnt == HBW'(HB_TICKS - 1)) begin
                hb     <= ~hb;
                hb_cnt <= '0;
            end else begin
                hb_cnt <= hb_cnt + 1'b1;
            end
        end
    end

    assign idle_led = {7'b0, hb};
`else
    assign idle_led = 8'h00;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            bus.led  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= HOLD;
                        owner    <= pick;
                        hold_cnt <= '0;
                        bus.gnt  <= pick_onehot;
                        bus.busy <= 1'b1;
                        bus.led  <= 8'h00;
                    end else begin
                        bus.led  <= idle_led;
                    end
                end
                HOLD: begin
                    if (hold_exit) begin
                        state    <= GAP;
                        rr_ptr   <= next_ptr;
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        bus.led  <= 8'h00;
                    end else begin
                        bus.led <= pat_arr[owner];
                        if (tick) hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: begin
                    state   <= IDLE;
                    bus.led <= 8'h00;
                end
                default: begin
                    state    <= IDLE;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    bus.led  <= 8'h00;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.gnt));
    a_busy_match: assert property (@(posedge clk) disable iff (!reset) bus.busy == (|bus.gnt));

endmodule
